// File: rtl/clock_12h_controller.sv
// 12-hour wall clock sequencer: seconds/minutes/AM-PM state, external hour counter control
// and a two-step button-driven set mode (hours, then minutes).
module clock_12h_controller #(
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned HR_INIT = 12
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Mode,
    input  logic       Inc,
    input  logic [3:0] Hour_q,
    output logic       Hr_en,
    output logic       Hr_load,
    output logic [3:0] Hr_d,
    output logic [5:0] Min,
    output logic [5:0] Sec,
    output logic       Pm,
    output logic [1:0] State
);

    localparam logic [5:0] SecMax = 6'(SEC_MAX);
    localparam logic [5:0] MinMax = 6'(MIN_MAX);

    typedef enum logic [1:0] {
        StInit   = 2'b00,
        StRun    = 2'b01,
        StSetHr  = 2'b10,
        StSetMin = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       pm_q, pm_d;
    logic       hr_en_q, hr_en_d;
    logic       hr_load_q, hr_load_d;

    logic sec_last, min_last, inc_ok;

    assign sec_last = (sec_q == SecMax);
    assign min_last = (min_q == MinMax);
    // Mode beats Inc, and an Inc landing on a live Hr_en pulse is dropped.
    assign inc_ok   = Inc && !Mode && !hr_en_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   if (hr_load_q) state_d = StRun;
            StRun:    if (Mode) state_d = StSetHr;
            StSetHr:  if (Mode) state_d = StSetMin;
            StSetMin: if (Mode) state_d = StRun;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        sec_d     = sec_q;
        min_d     = min_q;
        pm_d      = pm_q;
        hr_en_d   = 1'b0;
        hr_load_d = 1'b0;

        // Hour counter steps 11 -> 12 on this edge, so the half-day flips.
        if (hr_en_q && (Hour_q == 4'd11)) pm_d = !pm_q;

        unique case (state_q)
            StInit: begin
                // First post-reset cycle raises the load; the load cycle then leaves INIT.
                hr_load_d = !hr_load_q;
            end
            StRun: begin
                if (Tick) begin
                    if (sec_last) begin
                        sec_d = '0;
                        if (min_last) begin
                            min_d   = '0;
                            hr_en_d = !hr_en_q;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            StSetHr: begin
                hr_en_d = inc_ok;
            end
            StSetMin: begin
                if (Mode) begin
                    sec_d = '0;
                end else if (inc_ok) begin
                    min_d = min_last ? 6'd0 : min_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sec_q     <= '0;
            min_q     <= '0;
            pm_q      <= 1'b0;
            hr_en_q   <= 1'b0;
            hr_load_q <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            min_q     <= min_d;
            pm_q      <= pm_d;
            hr_en_q   <= hr_en_d;
            hr_load_q <= hr_load_d;
        end
    end

    assign Hr_d    = 4'(HR_INIT);
    assign Hr_en   = hr_en_q;
    assign Hr_load = hr_load_q;
    assign Min     = min_q;
    assign Sec     = sec_q;
    assign Pm      = pm_q;
    assign State   = state_q;

endmodule

// File: tb/tb_clock_12h_controller.sv
// Directed bench for clock_12h_controller with a behavioural 1..12 hour counter attached.
module tb_clock_12h_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Tick, Mode, Inc;
    logic [3:0] Hour_q = 4'd0;
    logic       Hr_en, Hr_load;
    logic [3:0] Hr_d;
    logic [5:0] Min, Sec;
    logic       Pm;
    logic [1:0] State;

    int n_vec = 0;
    int n_err = 0;
    int en_pulses = 0;
    int en_double = 0;
    int load_cycles = 0;
    logic en_prev = 1'b0;
    int p0;

    clock_12h_controller dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Tick   (Tick),
        .Mode   (Mode),
        .Inc    (Inc),
        .Hour_q (Hour_q),
        .Hr_en  (Hr_en),
        .Hr_load(Hr_load),
        .Hr_d   (Hr_d),
        .Min    (Min),
        .Sec    (Sec),
        .Pm     (Pm),
        .State  (State)
    );

    always #5 Clk = ~Clk;

    // External hour counter: load wins, otherwise count 1..12 with wrap.
    always @(posedge Clk) begin
        if (Hr_load) Hour_q <= Hr_d;
        else if (Hr_en) Hour_q <= (Hour_q == 4'd12) ? 4'd1 : Hour_q + 4'd1;
    end

    always @(posedge Clk) begin
        if (Hr_en) en_pulses++;
        if (Hr_en && en_prev) en_double++;
        if (Hr_load) load_cycles++;
        en_prev = Hr_en;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic m, input logic i);
        Tick = t;
        Mode = m;
        Inc  = i;
        @(posedge Clk);
        #1;
        Tick = 1'b0;
        Mode = 1'b0;
        Inc  = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Set mode: h spaced hour increments, m spaced minute increments, back to RUN.
    task automatic set_time(input int h, input int m);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < h; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < m; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        Tick  = 1'b0;
        Mode  = 1'b0;
        Inc   = 1'b0;

        // 1: reset, then one load cycle, inputs ignored during INIT
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("rst_state", State, 0);
        check("rst_sec", Sec, 0);
        check("rst_min", Min, 0);
        check("rst_pm", Pm, 0);
        check("rst_hr_en", Hr_en, 0);
        check("rst_hr_load", Hr_load, 0);
        check("hr_d", Hr_d, 12);
        Reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        check("init_state", State, 0);
        check("init_load", Hr_load, 1);
        cyc(1'b1, 1'b1, 1'b1);
        check("run_state", State, 1);
        check("run_load", Hr_load, 0);
        check("load_cycles", load_cycles, 1);
        check("init_hour", Hour_q, 12);
        check("init_sec", Sec, 0);
        check("init_min", Min, 0);
        check("init_pm", Pm, 0);

        // 2: second and minute carries, hour rollover 12 -> 1
        run_ticks(59);
        check("sec_59", Sec, 59);
        run_ticks(1);
        check("carry_sec", Sec, 0);
        check("carry_min", Min, 1);
        run_ticks(3539);
        check("pre_roll_min", Min, 59);
        check("pre_roll_sec", Sec, 59);
        run_ticks(1);
        check("roll_min", Min, 0);
        check("roll_sec", Sec, 0);
        check("roll_hr_en", Hr_en, 1);
        cyc(1'b0, 1'b0, 1'b0);
        check("roll_hr_en_low", Hr_en, 0);
        check("roll_hour", Hour_q, 1);
        check("roll_pm", Pm, 0);
        check("roll_pulses", en_pulses, 1);

        // 3: 11:59:59 AM -> 12 PM, then 11:59:59 PM -> 12 AM
        set_time(10, 59);
        check("preset_hour", Hour_q, 11);
        check("preset_min", Min, 59);
        check("preset_state", State, 1);
        run_ticks(60);
        cyc(1'b0, 1'b0, 1'b0);
        check("noon_hour", Hour_q, 12);
        check("noon_pm", Pm, 1);
        check("noon_min", Min, 0);
        set_time(11, 59);
        check("preset_pm_hour", Hour_q, 11);
        check("preset_pm_pm", Pm, 1);
        run_ticks(60);
        cyc(1'b0, 1'b0, 1'b0);
        check("midnight_hour", Hour_q, 12);
        check("midnight_pm", Pm, 0);

        // 4: set hours +3, minutes +5 with Tick held high throughout
        run_ticks(5);
        cyc(1'b1, 1'b1, 1'b0);
        check("sethr_state", State, 2);
        check("sethr_sec", Sec, 6);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("sethr_hour", Hour_q, 3);
        check("sethr_frozen", Sec, 6);
        cyc(1'b1, 1'b1, 1'b0);
        check("setmin_state", State, 3);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("setmin_min", Min, 5);
        check("setmin_frozen", Sec, 6);
        cyc(1'b1, 1'b1, 1'b0);
        check("back_state", State, 1);
        check("back_sec", Sec, 0);
        check("back_min", Min, 5);
        check("back_hour", Hour_q, 3);
        check("back_pm", Pm, 0);

        // 5: back-to-back Inc gives one pulse; Mode beats Inc
        cyc(1'b0, 1'b1, 1'b0);
        p0 = en_pulses;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("b2b_pulses", en_pulses - p0, 1);
        check("b2b_hour", Hour_q, 4);
        cyc(1'b0, 1'b1, 1'b1);
        check("mi_hr_state", State, 3);
        check("mi_hr_en", Hr_en, 0);
        cyc(1'b0, 1'b1, 1'b1);
        check("mi_min_state", State, 1);
        check("mi_min", Min, 5);
        check("mi_hour", Hour_q, 4);
        check("no_double", en_double, 0);

        // 6: reset in a set mode with an hour increment requested
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("pre_rst_state", State, 3);
        p0 = en_pulses;
        Reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        check("mid_rst_state", State, 0);
        check("mid_rst_min", Min, 0);
        check("mid_rst_hr_en", Hr_en, 0);
        Reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        check("rst2_load", Hr_load, 1);
        Reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("rst3_hr_en", Hr_en, 0);
        check("rst3_pulses", en_pulses - p0, 0);
        check("rst3_state", State, 1);
        check("rst3_hour", Hour_q, 12);
        check("rst3_min", Min, 0);
        check("rst3_sec", Sec, 0);
        check("rst3_pm", Pm, 0);
        check("rst3_loads", load_cycles, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
